wb_master: RTL and testbench

WB_MASTER -- requirements
Module: wb_master

---
 rtl/wb_master_if.sv | 43 ++++
 rtl/wb_master.sv | 113 +++++++++++
 tb/tb_wb_master.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_master_if.sv
// Command, response and Wishbone master signal bundle for wb_master.
// The master modport is the block's view; the slave modport is its environment's view.
`timescale 1ns/1ps
interface wb_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [3:0]  cmd_sel;
    logic [31:0] cmd_dat;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;

    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_o;
    logic        wb_ack_i;
    logic [31:0] wb_dat_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_sel, cmd_dat,
        output cmd_ready,
        output rsp_valid, rsp_dat, rsp_err,
        input  rsp_ready,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
        input  wb_ack_i, wb_dat_i
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_sel, cmd_dat,
        input  cmd_ready,
        input  rsp_valid, rsp_dat, rsp_err,
        output rsp_ready,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
        output wb_ack_i, wb_dat_i
    );
endinterface

// File: rtl/wb_master.sv
// Single-transfer Wishbone master: one command in, one classic bus cycle, one response out.
// Optional bus timeout enabled by defining WB_MASTER_TIMEOUT_EN.
`timescale 1ns/1ps
module wb_master #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd255
) (
    input  logic       clk,
    input  logic       reset_n,
    wb_master_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t state_r;

    if (TIMEOUT_CYCLES < 32'd1 || TIMEOUT_CYCLES > 32'd255) begin : g_bad_timeout
        $error("wb_master: TIMEOUT_CYCLES must be within 1..255");
    end

`ifdef WB_MASTER_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 32'd1);
    logic [7:0] tmo_cnt_r;
`endif

    // Transaction sequencer; every output is a register updated with the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            bus.cmd_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_dat   <= 32'd0;
            bus.wb_cyc_o  <= 1'b0;
            bus.wb_stb_o  <= 1'b0;
            bus.wb_we_o   <= 1'b0;
            bus.wb_adr_o  <= 32'd0;
            bus.wb_sel_o  <= 4'd0;
            bus.wb_dat_o  <= 32'd0;
`ifdef WB_MASTER_TIMEOUT_EN
            tmo_cnt_r     <= 8'd0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // cmd_ready is 1 throughout IDLE, so cmd_valid alone is the handshake.
                    if (bus.cmd_valid) begin
                        bus.wb_we_o   <= bus.cmd_we;
                        bus.wb_adr_o  <= bus.cmd_adr;
                        bus.wb_sel_o  <= bus.cmd_sel;
                        bus.wb_dat_o  <= bus.cmd_dat;
                        bus.wb_cyc_o  <= 1'b1;
                        bus.wb_stb_o  <= 1'b1;
                        bus.cmd_ready <= 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
                        tmo_cnt_r     <= 8'd0;
`endif
                        state_r       <= ST_BUS;
                    end else begin
                        state_r       <= ST_IDLE;
                    end
                end
                ST_BUS: begin
                    if (bus.wb_ack_i) begin
                        bus.wb_cyc_o  <= 1'b0;
                        bus.wb_stb_o  <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_dat   <= bus.wb_we_o ? 32'd0 : bus.wb_dat_i;
                        state_r       <= ST_RESP;
                    end
`ifdef WB_MASTER_TIMEOUT_EN
                    else if (tmo_cnt_r == TMO_LAST) begin
                        bus.wb_cyc_o  <= 1'b0;
                        bus.wb_stb_o  <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_dat   <= 32'd0;
                        state_r       <= ST_RESP;
                    end else begin
                        tmo_cnt_r     <= tmo_cnt_r + 8'd1;
                    end
`else
                    else begin
                        state_r       <= ST_BUS;
                    end
`endif
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                        state_r       <= ST_IDLE;
                    end else begin
                        state_r       <= ST_RESP;
                    end
                end
                default: begin
                    // Unreachable encoding: drop any bus cycle and return to a clean IDLE.
                    bus.wb_cyc_o  <= 1'b0;
                    bus.wb_stb_o  <= 1'b0;
                    bus.rsp_valid <= 1'b0;
                    bus.cmd_ready <= 1'b1;
                    state_r       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_master.sv
// Randomized scoreboard bench for wb_master: a driver queues expected responses,
// a behavioural slave and a response monitor check the DUT independently.
`timescale 1ns/1ps
module tb_wb_master;

`ifdef WB_MASTER_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif
    localparam int TMO = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    wb_master_if bus();

    wb_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [31:0] rdata;
        int          delay;
    } plan_t;

    typedef struct {
        logic [31:0] dat;
        logic        err;
        int          bp;
    } exp_t;

    plan_t plan_q[$];
    exp_t  exp_q[$];
    int    checks = 0;
    int    failures = 0;
    int    cycle = 0;
    int    scnt = 0;
    plan_t sp;
    bit    have_p = 1'b0;

    initial forever begin
        @(posedge clk);
        cycle = cycle + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: a timeout wins only when ack has not come within TMO strobe cycles.
    function automatic bit m_err(input int delay);
        return TMO_ON && (delay >= TMO);
    endfunction

    function automatic int m_len(input int delay);
        return m_err(delay) ? TMO : delay + 1;
    endfunction

    task automatic issue(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat, input logic [31:0] rdata,
                         input int delay, input int bp, input bit respond, output int acc);
        plan_t p;
        exp_t  e;
        int    waited;
        p.we = we; p.adr = adr; p.sel = sel; p.dat = dat; p.rdata = rdata; p.delay = delay;
        plan_q.push_back(p);
        if (respond) begin
            e.err = m_err(delay);
            e.dat = e.err ? 32'd0 : (we ? 32'd0 : rdata);
            e.bp  = bp;
            exp_q.push_back(e);
        end
        bus.cmd_we = we; bus.cmd_adr = adr; bus.cmd_sel = sel; bus.cmd_dat = dat;
        bus.cmd_valid = 1'b1;
        waited = 0;
        while (!bus.cmd_ready && waited < 300) begin
            @(negedge clk);
            waited = waited + 1;
        end
        if (!bus.cmd_ready) begin
            checks = checks + 1;
            failures = failures + 1;
            $display("FAIL cmd_accept: cmd_ready stayed 0 for %0d cycles, expected 1", waited);
            bus.cmd_valid = 1'b0;
            acc = -1;
        end else begin
            @(posedge clk);
            #1;
            bus.cmd_valid = 1'b0;
            bus.cmd_dat = $urandom;
            acc = cycle;
        end
    endtask

    // Behavioural Wishbone slave: acks after the planned delay, checks bus fields and strobe length.
    initial begin
        bus.wb_ack_i = 1'b0;
        bus.wb_dat_i = 32'd0;
        forever begin
            @(negedge clk);
            if (bus.wb_cyc_o || bus.wb_stb_o) begin
                if (scnt == 0) begin
                    if (plan_q.size() == 0) begin
                        checks = checks + 1;
                        failures = failures + 1;
                        $display("FAIL unexpected_bus_cycle: adr=0x%08h with no command queued", bus.wb_adr_o);
                        have_p = 1'b0;
                    end else begin
                        sp = plan_q.pop_front();
                        have_p = 1'b1;
                    end
                end
                check("wb_cyc", 32'(bus.wb_cyc_o), 32'd1);
                check("wb_stb", 32'(bus.wb_stb_o), 32'd1);
                if (have_p) begin
                    check("wb_adr", bus.wb_adr_o, sp.adr);
                    check("wb_sel", 32'(bus.wb_sel_o), 32'(sp.sel));
                    check("wb_we", 32'(bus.wb_we_o), 32'(sp.we));
                    check("wb_dat_o", bus.wb_dat_o, sp.dat);
                end
                bus.wb_ack_i = have_p && (scnt == sp.delay);
                bus.wb_dat_i = bus.wb_ack_i ? sp.rdata : $urandom;
                scnt = scnt + 1;
            end else begin
                if (scnt != 0 && have_p) begin
                    check("stb_cycles", 32'(scnt), 32'(m_len(sp.delay)));
                end
                scnt = 0;
                bus.wb_ack_i = 1'($urandom_range(0, 1));
                bus.wb_dat_i = $urandom;
            end
        end
    end

    // Response monitor: applies planned backpressure, checks hold stability and the scoreboard.
    initial begin
        bit    in_rsp = 1'b0;
        bit    have = 1'b0;
        int    hold = 0;
        exp_t  cur;
        logic [31:0] held_dat;
        logic        held_err;
        bus.rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                bus.rsp_ready = 1'b0;
                in_rsp = 1'b0;
            end else if (bus.rsp_valid) begin
                if (!in_rsp) begin
                    in_rsp = 1'b1;
                    held_dat = bus.rsp_dat;
                    held_err = bus.rsp_err;
                    if (exp_q.size() == 0) begin
                        checks = checks + 1;
                        failures = failures + 1;
                        $display("FAIL unexpected_rsp: rsp_dat=0x%08h with nothing expected", bus.rsp_dat);
                        have = 1'b0;
                        hold = 0;
                    end else begin
                        cur = exp_q.pop_front();
                        have = 1'b1;
                        hold = cur.bp;
                    end
                end else begin
                    check("rsp_dat_stable", bus.rsp_dat, held_dat);
                    check("rsp_err_stable", 32'(bus.rsp_err), 32'(held_err));
                end
                check("cmd_ready_busy", 32'(bus.cmd_ready), 32'd0);
                if (hold == 0) begin
                    bus.rsp_ready = 1'b1;
                    in_rsp = 1'b0;
                    if (have) begin
                        check("rsp_dat", bus.rsp_dat, cur.dat);
                        check("rsp_err", 32'(bus.rsp_err), 32'(cur.err));
                    end
                end else begin
                    hold = hold - 1;
                    bus.rsp_ready = 1'b0;
                end
            end else begin
                bus.rsp_ready = 1'($urandom_range(0, 1));
                in_rsp = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Driver: directed scenarios first, then randomized traffic.
    initial begin
        int acc;
        int prev;
        int pre;
        int waited;
        bus.cmd_valid = 1'b0;
        bus.cmd_we = 1'b0;
        bus.cmd_adr = 32'd0;
        bus.cmd_sel = 4'd0;
        bus.cmd_dat = 32'd0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_rsp_dat", bus.rsp_dat, 32'd0);
        check("rst_cyc", 32'(bus.wb_cyc_o), 32'd0);
        check("rst_stb", 32'(bus.wb_stb_o), 32'd0);
        check("rst_we", 32'(bus.wb_we_o), 32'd0);
        check("rst_adr", bus.wb_adr_o, 32'd0);
        check("rst_sel", 32'(bus.wb_sel_o), 32'd0);
        check("rst_dat", bus.wb_dat_o, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        pre = cycle;
        issue(1'b1, 32'h0000_0014, 4'hF, 32'hA5A5_0001, 32'h1234_5678, 1, 0, 1'b1, acc);
        check("first_accept_after_reset", 32'(acc), 32'(pre + 1));
        @(negedge clk);
        issue(1'b0, 32'h0000_0010, 4'hF, 32'h0, 32'hDEAD_BEEF, 0, 5, 1'b1, acc);
        @(negedge clk);
        issue(1'b0, 32'h0000_0020, 4'h3, 32'h0, 32'hCAFE_0001, 10, 1, 1'b1, acc);
        @(negedge clk);
        issue(1'b0, 32'h0000_0024, 4'hC, 32'h0, 32'hCAFE_0002, TMO - 1, 0, 1'b1, acc);
        @(negedge clk);
        issue(1'b1, 32'h0000_0028, 4'h1, 32'h5555_AAAA, 32'h0, TMO, 2, 1'b1, acc);

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            issue(1'b0, 32'h100 + 32'(i * 4), 4'hF, 32'h0, $urandom, 0, 0, 1'b1, acc);
            if (i > 0) check("cmd_period", 32'(acc - prev), 32'd3);
            prev = acc;
        end

        @(negedge clk);
        issue(1'b1, 32'h0000_0200, 4'hF, 32'hFFFF_0000, 32'h0, 50, 0, 1'b0, acc);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_cyc", 32'(bus.wb_cyc_o), 32'd0);
        check("mid_rst_stb", 32'(bus.wb_stb_o), 32'd0);
        check("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("mid_rst_adr", bus.wb_adr_o, 32'd0);
        #1;
        reset_n = 1'b1;
        scnt = 0;
        pre = cycle;
        issue(1'b0, 32'h0000_0300, 4'h6, 32'h0, 32'h0BAD_F00D, 2, 1, 1'b1, acc);
        check("accept_after_mid_rst", 32'(acc), 32'(pre + 1));

        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            issue(1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom, $urandom,
                  $urandom_range(0, TMO_ON ? 7 : 5), $urandom_range(0, 3), 1'b1, acc);
        end

        waited = 0;
        while ((exp_q.size() != 0 || bus.rsp_valid) && waited < 500) begin
            @(negedge clk);
            waited = waited + 1;
        end
        repeat (3) @(negedge clk);
        check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        check("plan_queue_drained", 32'(plan_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
